// File: rtl/ysyx_lsu.sv
// ysyx_lsu: load/store unit. Takes the decoder's load/store selects with the
// ALU address and rs2 data, runs one data-memory transaction over a valid/ready
// request/response bus, and hands back the aligned, extended load result.
// Optional feature macro: YSYX_LSU_MISALIGN_EXC_EN. When it is defined,
// misaligned half/word accesses skip memory and raise misalign instead.
module ysyx_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    dm_rd_sel,
    input  logic [1:0]    dm_wr_sel,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic          mem_req_wen,
    output logic [AW-1:0] mem_req_addr,
    output logic [DW-1:0] mem_req_wdata,
    output logic [3:0]    mem_req_wmask,
    input  logic          mem_resp_valid,
    input  logic [DW-1:0] mem_resp_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_rdata,
    output logic          misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [2:0]    r_rd_sel;
    logic [1:0]    r_wr_sel;
    logic [1:0]    r_off;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_wmask;
    logic [DW-1:0] r_rdata;

    logic [DW-1:0] w_st_wdata;
    logic [3:0]    w_st_wmask;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_ld_data;
    logic          w_is_noop;
    logic          w_misalign_in;

    assign w_is_noop = (dm_rd_sel == 3'b000) && (dm_wr_sel == 2'b00);

    // Replicate store data across lanes and build the byte mask from the low address bits
    always_comb begin
        w_st_wdata = '0;
        w_st_wmask = 4'b0000;
        case (dm_wr_sel)
            2'b01: begin
                w_st_wdata = {4{wdata[7:0]}};
                w_st_wmask = 4'b0001 << addr[1:0];
            end
            2'b10: begin
                w_st_wdata = {2{wdata[15:0]}};
                w_st_wmask = 4'b0011 << {addr[1], 1'b0};
            end
            2'b11: begin
                w_st_wdata = wdata;
                w_st_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    assign w_byte = mem_resp_rdata[{r_off, 3'b000} +: 8];
    assign w_half = mem_resp_rdata[{r_off[1], 4'b0000} +: 16];

    // Pick the byte/half/word out of the returned word and sign- or zero-extend it
    always_comb begin
        w_ld_data = '0;
        case (r_rd_sel)
            3'b001:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b010:  w_ld_data = {24'b0, w_byte};
            3'b011:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {16'b0, w_half};
            3'b101:  w_ld_data = mem_resp_rdata;
            default: w_ld_data = '0;
        endcase
    end

`ifdef YSYX_LSU_MISALIGN_EXC_EN
    logic r_misalign;

    // Flag half/word accesses whose offset does not fit their size; stores win over loads
    always_comb begin
        w_misalign_in = 1'b0;
        if (dm_wr_sel != 2'b00) begin
            w_misalign_in = ((dm_wr_sel == 2'b10) && addr[0]) ||
                            ((dm_wr_sel == 2'b11) && (addr[1:0] != 2'b00));
        end else begin
            w_misalign_in = (((dm_rd_sel == 3'b011) || (dm_rd_sel == 3'b100)) && addr[0]) ||
                            ((dm_rd_sel == 3'b101) && (addr[1:0] != 2'b00));
        end
    end

    // Hold the misalign flag for exactly the DONE period of a faulting access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_misalign <= w_misalign_in;
        end else if (r_state == S_DONE && out_ready) begin
            r_misalign <= 1'b0;
        end
    end

    assign misalign = r_misalign;
`else
    assign w_misalign_in = 1'b0;
    assign misalign      = 1'b0;
`endif

    // Main transaction FSM: accept, issue request, wait for response, present result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rd_sel <= 3'b000;
            r_wr_sel <= 2'b00;
            r_off    <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= 4'b0000;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rd_sel <= dm_rd_sel;
                        r_wr_sel <= dm_wr_sel;
                        r_off    <= addr[1:0];
                        r_addr   <= {addr[AW-1:2], 2'b00};
                        r_wdata  <= w_st_wdata;
                        r_wmask  <= w_st_wmask;
                        r_rdata  <= '0;
                        if (w_is_noop || w_misalign_in) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_rdata <= (r_wr_sel != 2'b00) ? '0 : w_ld_data;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready      = (r_state == S_IDLE);
    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_wen   = (r_wr_sel != 2'b00);
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_wmask = r_wmask;
    assign out_valid     = (r_state == S_DONE);
    assign out_rdata     = r_rdata;

endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu: self-checking bench for ysyx_lsu. Each operation pushes its
// expected result into a scoreboard queue; the entry is popped and compared
// when the LSU presents out_valid. The bench plays the memory side itself.
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  dm_rd_sel;
    logic [1:0]  dm_wr_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        misalign;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sbQueue[$];

    // Free-running clock
    always #5 clk = ~clk;

    ysyx_lsu #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dm_rd_sel     (dm_rd_sel),
        .dm_wr_sel     (dm_wr_sel),
        .addr          (addr),
        .wdata         (wdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .misalign      (misalign)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] b2w(input logic b);
        return {31'b0, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference load extraction, written with plain shifts
    function automatic logic [31:0] modelLoad(input logic [2:0] rd, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * int'(off));
        h = w >> (off[1] ? 16 : 0);
        case (rd)
            3'b001:  return {{24{b[7]}}, b[7:0]};
            3'b010:  return {24'b0, b[7:0]};
            3'b011:  return {{16{h[15]}}, h[15:0]};
            3'b100:  return {16'b0, h[15:0]};
            3'b101:  return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkReq(input string tag, input logic [31:0] expAddr, input logic expWen,
                            input logic [3:0] expMask, input logic [31:0] expWdata);
        checkOutput({tag, "_reqv"}, b2w(mem_req_valid), 32'd1);
        checkOutput({tag, "_inrdy"}, b2w(in_ready), 32'd0);
        checkOutput({tag, "_addr"}, mem_req_addr, expAddr);
        checkOutput({tag, "_wen"}, b2w(mem_req_wen), b2w(expWen));
        if (expWen) begin
            checkOutput({tag, "_mask"}, {28'b0, mem_req_wmask}, {28'b0, expMask});
            checkOutput({tag, "_wdata"}, mem_req_wdata, expWdata);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] rd, input logic [1:0] wr,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] memData,
                                 input logic expReq, input logic [31:0] expAddr, input logic [3:0] expMask,
                                 input logic [31:0] expWdata, input logic [31:0] expRdata,
                                 input logic expMis, input int reqStall, input int outStall);
        int cyc;
        int waited;
        logic [31:0] expected;
        checkOutput({tag, "_idle_rdy"}, b2w(in_ready), 32'd1);
        in_valid  = 1'b1;
        dm_rd_sel = rd;
        dm_wr_sel = wr;
        addr      = a;
        wdata     = wd;
        sbQueue.push_back(expRdata);
        step();
        in_valid = 1'b0;
        cyc = 1;
        if (expReq) begin
            for (int s = 0; s < reqStall; s++) begin
                checkReq({tag, "_stall"}, expAddr, wr != 2'b00, expMask, expWdata);
                step();
                cyc++;
            end
            checkReq(tag, expAddr, wr != 2'b00, expMask, expWdata);
            mem_req_ready = 1'b1;
            step();
            cyc++;
            mem_req_ready = 1'b0;
            checkOutput({tag, "_wait_reqv"}, b2w(mem_req_valid), 32'd0);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = memData;
            step();
            cyc++;
            mem_resp_valid = 1'b0;
        end else begin
            checkOutput({tag, "_noreq"}, b2w(mem_req_valid), 32'd0);
        end
        waited = 0;
        while (!out_valid && waited < 20) begin
            step();
            cyc++;
            waited++;
        end
        checkOutput({tag, "_outv"}, b2w(out_valid), 32'd1);
        checkOutput({tag, "_lat"}, cyc, expReq ? 32'(3 + reqStall) : 32'd1);
        for (int s = 0; s < outStall; s++) begin
            checkOutput({tag, "_hold_v"}, b2w(out_valid), 32'd1);
            checkOutput({tag, "_hold_d"}, out_rdata, sbQueue[0]);
            checkOutput({tag, "_hold_inrdy"}, b2w(in_ready), 32'd0);
            step();
        end
        expected = sbQueue.pop_front();
        checkOutput({tag, "_rdata"}, out_rdata, expected);
        checkOutput({tag, "_mis"}, b2w(misalign), b2w(expMis));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput({tag, "_retire_v"}, b2w(out_valid), 32'd0);
        checkOutput({tag, "_retire_mis"}, b2w(misalign), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_inrdy"}, b2w(in_ready), 32'd1);
        checkOutput({tag, "_reqv"}, b2w(mem_req_valid), 32'd0);
        checkOutput({tag, "_outv"}, b2w(out_valid), 32'd0);
        checkOutput({tag, "_rdata"}, out_rdata, 32'd0);
        checkOutput({tag, "_mis"}, b2w(misalign), 32'd0);
        checkOutput({tag, "_wen"}, b2w(mem_req_wen), 32'd0);
        checkOutput({tag, "_mask"}, {28'b0, mem_req_wmask}, 32'd0);
    endtask

    // Watchdog so the run always ends even if the DUT wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random stimulus
    initial begin
        logic [2:0]  rd;
        logic [31:0] a;
        logic [31:0] d;
        rst = 1'b1;
        in_valid = 1'b0;
        dm_rd_sel = 3'b000;
        dm_wr_sel = 2'b00;
        addr = 32'h0;
        wdata = 32'h0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checkResetState("reset");

        applyStimulus("sw",   3'b000, 2'b11, 32'h80000004, 32'hDEADBEEF, 32'h0,
                      1'b1, 32'h80000004, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0);
        applyStimulus("sb",   3'b000, 2'b01, 32'h80000003, 32'h000000A5, 32'h0,
                      1'b1, 32'h80000000, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 0, 0);
        applyStimulus("sh",   3'b000, 2'b10, 32'h80000002, 32'h1234ABCD, 32'h0,
                      1'b1, 32'h80000000, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 0, 0);
        applyStimulus("lh",   3'b011, 2'b00, 32'h80000002, 32'h0, 32'h80F00000,
                      1'b1, 32'h80000000, 4'b0000, 32'h0, 32'hFFFF80F0, 1'b0, 0, 0);
        applyStimulus("lhu",  3'b100, 2'b00, 32'h80000002, 32'h0, 32'h80F00000,
                      1'b1, 32'h80000000, 4'b0000, 32'h0, 32'h000080F0, 1'b0, 0, 0);
        applyStimulus("lb",   3'b001, 2'b00, 32'h80000003, 32'h0, 32'h80F00000,
                      1'b1, 32'h80000000, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 0, 0);
        applyStimulus("lbu",  3'b010, 2'b00, 32'h80000001, 32'h0, 32'h11223344,
                      1'b1, 32'h80000000, 4'b0000, 32'h0, 32'h00000033, 1'b0, 0, 0);
        applyStimulus("lw_stall", 3'b101, 2'b00, 32'h80000008, 32'h0, 32'hCAFEF00D,
                      1'b1, 32'h80000008, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 5, 3);
        applyStimulus("noop", 3'b000, 2'b00, 32'h80000010, 32'h12345678, 32'h0,
                      1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 0, 0);
        applyStimulus("both", 3'b101, 2'b11, 32'h80000010, 32'h00000055, 32'hFFFFFFFF,
                      1'b1, 32'h80000010, 4'b1111, 32'h00000055, 32'h0, 1'b0, 0, 0);
`ifdef YSYX_LSU_MISALIGN_EXC_EN
        applyStimulus("lw_mis", 3'b101, 2'b00, 32'h80000001, 32'h0, 32'h89ABCDEF,
                      1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 0, 0);
`else
        applyStimulus("lw_mis", 3'b101, 2'b00, 32'h80000001, 32'h0, 32'h89ABCDEF,
                      1'b1, 32'h80000000, 4'b0000, 32'h0, 32'h89ABCDEF, 1'b0, 0, 0);
`endif

        for (int i = 0; i < 6; i++) begin
            rd = 3'($urandom_range(1, 5));
            a = $urandom;
            a[31:28] = 4'h8;
            if (rd == 3'b101) a[1:0] = 2'b00;
            else if (rd >= 3'b011) a[0] = 1'b0;
            d = $urandom;
            applyStimulus("rnd", rd, 2'b00, a, 32'h0, d, 1'b1, {a[31:2], 2'b00}, 4'b0000, 32'h0,
                          modelLoad(rd, a[1:0], d), 1'b0, i % 2, i % 3);
        end

        // Abandon a load in WAIT with reset, then send a stray response
        in_valid = 1'b1;
        dm_rd_sel = 3'b101;
        dm_wr_sel = 2'b00;
        addr = 32'h80000020;
        step();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetState("midrst");
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h12345678;
        step();
        mem_resp_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            checkOutput("stray_outv", b2w(out_valid), 32'd0);
            checkOutput("stray_inrdy", b2w(in_ready), 32'd1);
            step();
        end

        // Reset asserted together with a no-op request must win
        rst = 1'b1;
        in_valid = 1'b1;
        dm_rd_sel = 3'b000;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        checkOutput("rstwin_outv", b2w(out_valid), 32'd0);
        checkOutput("rstwin_inrdy", b2w(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_lsu.md
Name: ysyx_lsu

Overview:
- Load/store unit at the far end of the decoder's memory-control interface.
- Consumes the decoder's dm_rd_sel/dm_wr_sel encodings plus the ALU-computed address and rs2 data, and runs one data-memory transaction over a valid/ready request and response bus.
- Returns the aligned, sign- or zero-extended load result to the writeback stage, which selects it when rf_wr_sel=3'b011.

Parameters:
- AW, 32, address width.
- DW, 32, data width; fixed at 32, byte lanes = DW/8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  LSU can accept an operation.
- dm_rd_sel  in  3  load type: 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 000 none.
- dm_wr_sel  in  2  store type: 01 sb, 10 sh, 11 sw, 00 none.
- addr  in  AW  effective byte address.
- wdata  in  DW  rs2 value to store.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00}).
- mem_req_wdata  out  DW  lane-shifted store data.
- mem_req_wmask  out  4  byte-write mask.
- mem_resp_valid  in  1  response or write acknowledge.
- mem_resp_rdata  in  DW  raw read word.
- out_valid  out  1  result available.
- out_ready  in  1  downstream consumes the result.
- out_rdata  out  DW  extended load data; 0 for stores and no-ops.
- misalign  out  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset is synchronous; rst wins over every other input in the same cycle.
- Reset values: FSM=IDLE, in_ready=1, mem_req_valid=0, out_valid=0, out_rdata=0, misalign=0, mem_req_wen=0, mem_req_wmask=0.
- rst asserted mid-transaction abandons it. Any later mem_resp_valid that arrives while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch dm_rd_sel, dm_wr_sel, addr[1:0] and the shifted wdata/mask.
  - If both selects are 0, go to DONE with out_rdata=0.
  - Otherwise go to REQ.
  - If both selects are nonzero, the store takes priority and the load is ignored.
- REQ:
  - mem_req_valid=1. The request fields are held stable until mem_req_ready.
  - On mem_req_valid && mem_req_ready, go to WAIT.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: for loads, latch the extended data into out_rdata; for stores, set out_rdata=0. Then go to DONE.
  - mem_resp_valid is only sampled in WAIT. The memory never responds in the acceptance cycle.
- DONE:
  - out_valid=1, with out_rdata held.
  - On out_ready, go to IDLE.
- in_ready=1 only in IDLE. A new operation is never accepted in the same cycle that DONE retires.
- Minimum latency, acceptance to out_valid:
  - Memory op: 3 cycles when mem_req_ready=1 in REQ and the response arrives the next cycle.
  - No-op: 1 cycle.
- Store lanes, with off = addr[1:0]:
  - sb: mask = 4'b0001 << off; wdata = {4{wdata[7:0]}}.
  - sh: mask = 4'b0011 << {off[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - sw: mask = 4'b1111; wdata unchanged.
- Load extract:
  - Byte = rdata[8*off +: 8].
  - Half = rdata[16*off[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the full word.
- Without the optional feature, misaligned halfword accesses silently use off[1] and words ignore off. The address is always truncated, never wrapped across words.

Optional Feature:
- Macro: YSYX_LSU_MISALIGN_EXC_EN.
- Defined:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, goes IDLE -> DONE directly.
  - No memory request is issued.
  - out_rdata=0 and misalign=1 for the duration of DONE; misalign clears on leaving DONE.
- Undefined:
  - misalign is tied to 0.
  - Misaligned accesses follow the truncation rules in Behaviour.

Test Plan:
- sw at addr=0x80000004, wdata=0xDEADBEEF, mem_req_ready=1, ack 1 cycle later -> one request with wen=1, addr=0x80000004, mask=4'b1111, wdata=0xDEADBEEF; out_valid 3 cycles after acceptance with out_rdata=0.
- sb at addr=0x80000003, wdata=0x000000A5 -> mask=4'b1000, mem_req_wdata=0xA5A5A5A5.
- Load at addr=0x80000002 with mem_resp_rdata=0x80F00000:
  - lh -> out_rdata=0xFFFF80F0.
  - lhu -> out_rdata=0x000080F0.
  - lb at addr=0x80000003 -> out_rdata=0xFFFFFF80.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and all request fields stay stable; in_ready=0 throughout; no second request.
- out_ready held 0 for 3 cycles in DONE -> out_valid and out_rdata held. Then assert rst for 1 cycle during a later WAIT -> all outputs at reset values next cycle; a subsequent stray mem_resp_valid produces no out_valid.
- With YSYX_LSU_MISALIGN_EXC_EN defined, lw at addr=0x80000001 -> no mem_req_valid, out_valid=1 and misalign=1 one cycle after acceptance, out_rdata=0.
